// File: rtl/rom_dump_sequencer.sv
// Whole-chip PROM dump engine: sweeps every address, waits for the bus to settle,
// samples the data lines and streams one byte per address plus a trailing checksum.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | chip deselected, waiting for start
// ST_SETTLE   | address/selects driven, counting settle cycles
// ST_SAMPLE   | capture data bus into tx_data, accumulate checksum
// ST_SEND     | hold data byte until the transmitter accepts it
// ST_CHECKSUM | hold checksum byte until the transmitter accepts it
// ST_FINISH   | one-cycle done pulse, then back to idle
module rom_dump_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int SELECT_WIDTH  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [SELECT_WIDTH-1:0]  operation,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_SEND,
        ST_CHECKSUM,
        ST_FINISH
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         counter, counter_nxt;
    logic [7:0]               checksum, checksum_nxt;
    logic [ADDRESS_WIDTH-1:0] address_nxt;
    logic [SELECT_WIDTH-1:0]  operation_nxt;
    logic [7:0]               tx_data_nxt;
    logic                     tx_valid_nxt;
    logic [7:0]               sample_byte;
    logic                     handshake;
    logic                     last_address;

    assign sample_byte  = 8'(data_line_in);
    assign handshake    = tx_valid && tx_ready;
    assign last_address = (address_line == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            counter      <= '0;
            checksum     <= '0;
            address_line <= '0;
            operation    <= '1;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            counter      <= counter_nxt;
            checksum     <= checksum_nxt;
            address_line <= address_nxt;
            operation    <= operation_nxt;
            tx_data      <= tx_data_nxt;
            tx_valid     <= tx_valid_nxt;
            busy         <= (state_nxt != ST_IDLE);
            done         <= (state_nxt == ST_FINISH);
        end
    end

    always_comb begin
        state_nxt     = state;
        counter_nxt   = counter;
        checksum_nxt  = checksum;
        address_nxt   = address_line;
        operation_nxt = operation;
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = tx_valid;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt     = ST_SETTLE;
                    address_nxt   = '0;
                    operation_nxt = '0;
                    checksum_nxt  = '0;
                    counter_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (counter == SETTLE_LAST) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    counter_nxt = counter + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                tx_data_nxt  = sample_byte;
                checksum_nxt = checksum + sample_byte;
                tx_valid_nxt = 1'b1;
                state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    tx_valid_nxt = 1'b0;
                    if (last_address) begin
                        // checksum already includes the byte just accepted
                        state_nxt    = ST_CHECKSUM;
                        tx_data_nxt  = checksum;
                        tx_valid_nxt = 1'b1;
                    end else begin
                        address_nxt = address_line + ADDRESS_WIDTH'(1);
                        counter_nxt = '0;
                        state_nxt   = ST_SETTLE;
                    end
                end
            end
            ST_CHECKSUM: begin
                if (handshake) begin
                    operation_nxt = '1;
                    tx_valid_nxt  = 1'b0;
                    state_nxt     = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt   = ST_IDLE;
                address_nxt = '0;
                tx_data_nxt = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort && state != ST_IDLE) begin
            state_nxt     = ST_IDLE;
            tx_valid_nxt  = 1'b0;
            tx_data_nxt   = '0;
            operation_nxt = '1;
            address_nxt   = '0;
        end
    end

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Bench for rom_dump_sequencer: a PROM chip model with optional slow settling,
// a configurable transmitter, and a byte-stream reference built from the ROM contents.
module tb_rom_dump_sequencer;

    localparam int DW = 6;
    localparam int AW = 4;
    localparam int SW = 4;
    localparam int SC = 4;
    localparam int N  = 1 << AW;
    localparam int DUMP_CYCLES = N * (SC + 2) + 2;
    localparam logic [SW-1:0] SEL_OFF = '1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] data_line_in;
    logic [AW-1:0] address_line;
    logic [SW-1:0] operation;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] rom [N];
    bit            settle_mode = 1'b0;
    int            age = 15;
    logic [AW+SW-1:0] prev_pins = '0;

    int ready_mode = 0;
    int stall_left = 0;
    bit stalled = 1'b0;

    logic [7:0] rx_q [$];
    int busy_cycles = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0, prev_stall = 1'b0, prev_reset = 1'b1, prev_abort = 1'b0;
    logic [7:0]    prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    rom_dump_sequencer #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .SELECT_WIDTH(SW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .data_line_in(data_line_in),
        .address_line(address_line),
        .operation(operation),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done)
    );

    // Chip answers only when fully selected; in settle mode it shows all-ones
    // until three cycles after any address/select change.
    assign data_line_in = (operation != '0) ? '1 :
                          (settle_mode && age < 3) ? '1 : rom[address_line];

    always @(negedge clk) begin
        if ({address_line, operation} != prev_pins) begin
            age       <= 0;
            prev_pins <= {address_line, operation};
        end else if (age < 15) begin
            age <= age + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter: 0 always ready, 1 random, 2 one 10-cycle stall on byte 2, 3 never ready
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (stall_left > 0) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else if (!stalled && tx_valid && rx_q.size() == 2) begin
                    stalled    = 1'b1;
                    stall_left = 9;
                    tx_ready   = 1'b0;
                end else begin
                    tx_ready = 1'b1;
                end
            end
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (busy) busy_cycles++;
        if (done) begin
            done_cnt++;
            check("done_single_cycle", 32'(prev_done), 0);
        end
        if (!busy) begin
            check("idle_selects", 32'(operation), 32'(SEL_OFF));
            check("idle_valid", 32'(tx_valid), 0);
            check("idle_address", 32'(address_line), 0);
        end else if (!done) begin
            check("dump_selects", 32'(operation), 0);
        end
        if (prev_stall && !prev_reset && !prev_abort) begin
            check("hold_valid", 32'(tx_valid), 1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
            check("hold_address", 32'(address_line), 32'(prev_addr));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_addr  = address_line;
        prev_reset = reset;
        prev_abort = abort;
        prev_done  = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rx_q.delete();
        busy_cycles = 0;
        done_cnt    = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_rom_random();
        for (int a = 0; a < N; a++) rom[a] = DW'($urandom_range(0, (1 << DW) - 2));
    endtask

    task automatic compare_stream(input string name, input int n_bytes, input bit with_sum);
        logic [7:0] exp_q [$];
        int sum = 0;
        for (int a = 0; a < n_bytes; a++) begin
            exp_q.push_back(8'(rom[a]));
            sum += int'(rom[a]);
        end
        if (with_sum) exp_q.push_back(8'(sum % 256));
        check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size())
                check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
            else
                check($sformatf("%s_byte%0d", name, i), 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    task automatic run_dump(input string name, input bit extra_starts, input int exp_busy);
        bit ok = 1'b0;
        clear_stats();
        pulse_start();
        for (int i = 0; i < 2000 && !ok; i++) begin
            start = extra_starts && ($urandom_range(0, 5) == 0);
            @(negedge clk);
            if (done) ok = 1'b1;
            else tick();
        end
        start = 1'b0;
        check({name, "_finished"}, 32'(ok), 1);
        tick();
        tick();
        compare_stream(name, N, 1'b1);
        check({name, "_done_pulses"}, 32'(done_cnt), 1);
        if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        ready_mode = 0;
        fill_rom_random();

        // reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_selects", 32'(operation), 32'(SEL_OFF));
        check("rst_address", 32'(address_line), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        tick();
        reset = 1'b0;
        tick();

        run_dump("full", 1'b0, DUMP_CYCLES);

        fill_rom_random();
        ready_mode = 2;
        stalled = 1'b0;
        run_dump("backpressure", 1'b0, DUMP_CYCLES + 10);
        ready_mode = 0;

        fill_rom_random();
        settle_mode = 1'b1;
        run_dump("settle", 1'b0, DUMP_CYCLES);
        settle_mode = 1'b0;

        // abort during settle of address 2
        fill_rom_random();
        clear_stats();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (address_line == AW'(2) && !tx_valid) found = 1'b1;
        end
        check("abort_reached_addr2", 32'(found), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(tx_valid), 0);
        check("abort_selects", 32'(operation), 32'(SEL_OFF));
        check("abort_address", 32'(address_line), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (3) tick();
        compare_stream("abort", 2, 1'b0);
        check("abort_no_done", 32'(done_cnt), 0);
        run_dump("restart", 1'b0, DUMP_CYCLES);

        // start and abort together while idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", 32'(busy), 0);
        tick();
        @(negedge clk);
        check("start_abort_idle_selects", 32'(operation), 32'(SEL_OFF));
        tick();

        // all-ones ROM wraps the checksum; stray starts must be ignored
        for (int a = 0; a < N; a++) rom[a] = '1;
        run_dump("wrap", 1'b1, DUMP_CYCLES);

        fill_rom_random();
        ready_mode = 1;
        run_dump("random_ready", 1'b0, -1);

        // reset mid-SEND drops the pending byte
        fill_rom_random();
        ready_mode = 3;
        tick();
        clear_stats();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx_valid) found = 1'b1;
        end
        check("midsend_reached", 32'(found), 1);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midsend_rst_valid", 32'(tx_valid), 0);
        check("midsend_rst_selects", 32'(operation), 32'(SEL_OFF));
        check("midsend_rst_address", 32'(address_line), 0);
        check("midsend_rst_busy", 32'(busy), 0);
        check("midsend_rst_done", 32'(done), 0);
        check("midsend_no_bytes", 32'(rx_q.size()), 0);
        ready_mode = 0;
        tick();
        tick();
        run_dump("post_reset", 1'b0, DUMP_CYCLES);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
